// File: rtl/z_ing_op_sink.sv
// Receiving end of the z_ing op bus: FIFO-buffered op words decoded into a burst beat stream.
// Optional feature: define Z_ING_PARITY_EN to treat op[OPW-1] as an even-parity bit over op[OPW-2:0].
module z_ing_op_sink #(
   parameter int OPW   = 8,
   parameter int DW    = 16,
   parameter int DEPTH = 4,
   parameter int LEN   = 4
) (
   input  logic           clock,
   input  logic           rst,
   input  logic [OPW-1:0] in_op,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [DW-1:0]  out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_last,
   output logic           err_op,
   output logic [15:0]    op_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (LEN > 1) ? $clog2(LEN) : 1;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_BURST = 2'b10;

   typedef enum logic {
      S_IDLE,
      S_BURST
   } state_t;

   logic [OPW-1:0] mem_q [DEPTH];
   logic [AW-1:0]  wrPtr_q, wrPtr_d;
   logic [AW-1:0]  rdPtr_q, rdPtr_d;
   logic [CW-1:0]  count_q, count_d;
   state_t         state_q, state_d;
   logic [DW-1:0]  value_q, value_d;
   logic [BW-1:0]  beat_q, beat_d;
   logic           err_q, err_d;
   logic [15:0]    opCount_q, opCount_d;

   logic           push;
   logic           pop;
   logic [OPW-1:0] headOp;
   logic [1:0]     opcode;
   logic           parityBad;
   logic [DW-1:0]  payloadExt;
   logic           outValid;
   logic           outLast;
   logic [DW-1:0]  outData;

   assign headOp = mem_q[rdPtr_q];
   assign opcode = headOp[1:0];

`ifdef Z_ING_PARITY_EN
   logic [OPW-4:0] payload;
   assign payload   = headOp[OPW-2:2];
   assign parityBad = ^headOp;
`else
   logic [OPW-3:0] payload;
   assign payload   = headOp[OPW-1:2];
   assign parityBad = 1'b0;
`endif

   assign payloadExt = DW'(payload);

   // Ready comes purely from the registered fill level, so a full FIFO never accepts even if a pop is pending.
   assign in_ready = (count_q != CW'(DEPTH));
   assign push     = in_valid && in_ready;

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wrPtr_q] <= in_op;
      end
   end

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) begin
         wrPtr_d = wrPtr_q + AW'(1);
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Ops are only taken from the FIFO while idle; a burst owns the output until its last beat is accepted.
   always_comb begin
      state_d   = state_q;
      value_d   = value_q;
      beat_d    = beat_q;
      err_d     = 1'b0;
      opCount_d = opCount_q;
      pop       = 1'b0;
      outValid  = 1'b0;
      outLast   = 1'b0;
      outData   = '0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop       = 1'b1;
               opCount_d = opCount_q + 16'd1;
               if (parityBad) begin
                  err_d = 1'b1;
               end else begin
                  case (opcode)
                     OP_NOP:   ;
                     OP_LOAD:  value_d = payloadExt;
                     OP_BURST: begin
                        state_d = S_BURST;
                        beat_d  = '0;
                     end
                     default:  err_d = 1'b1;
                  endcase
               end
            end
         end
         S_BURST: begin
            outValid = 1'b1;
            outData  = value_q + DW'(beat_q);
            outLast  = (beat_q == BW'(LEN - 1));
            if (out_ready) begin
               if (outLast) begin
                  state_d = S_IDLE;
                  beat_d  = '0;
                  value_d = value_q + DW'(LEN);
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         state_q   <= S_IDLE;
         value_q   <= '0;
         beat_q    <= '0;
         err_q     <= 1'b0;
         opCount_q <= '0;
      end else begin
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         value_q   <= value_d;
         beat_q    <= beat_d;
         err_q     <= err_d;
         opCount_q <= opCount_d;
      end
   end

   assign out_valid = outValid;
   assign out_last  = outLast;
   assign out_data  = outData;
   assign err_op    = err_q;
   assign op_count  = opCount_q;

endmodule

// File: tb/tb_z_ing_op_sink.sv
// Scoreboard bench for z_ing_op_sink: a bench-side op model queues expected beats that a monitor retires.
module tb_z_ing_op_sink;

   logic        clock;
   logic        rst;
   logic [7:0]  in_op;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        err_op;
   logic [15:0] op_count;

   typedef struct {
      logic [15:0] data;
      logic        last;
   } beat_t;

   beat_t       expQ[$];
   logic [15:0] modelValue;
   logic [15:0] expOpCount;
   int          expErr;
   int          errSeen;
   int          beatSeen;
   int          checks;
   int          passes;

   z_ing_op_sink #(.OPW(8), .DW(16), .DEPTH(4), .LEN(4)) dut (
      .clock    (clock),
      .rst      (rst),
      .in_op    (in_op),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last (out_last),
      .err_op   (err_op),
      .op_count (op_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Mirrors the opcode semantics to predict beats, errors and the op counter.
   task automatic modelOp(input logic [7:0] op);
      logic [5:0] pay;
      logic       bad;
`ifdef Z_ING_PARITY_EN
      pay = {1'b0, op[6:2]};
      bad = ^op;
`else
      pay = op[7:2];
      bad = 1'b0;
`endif
      expOpCount = expOpCount + 16'd1;
      if (bad || op[1:0] == 2'b11) begin
         expErr++;
      end else if (op[1:0] == 2'b01) begin
         modelValue = 16'(pay);
      end else if (op[1:0] == 2'b10) begin
         for (int i = 0; i < 4; i++) begin
            expQ.push_back('{data: modelValue + 16'(i), last: (i == 3)});
         end
         modelValue = modelValue + 16'd4;
      end
   endtask

   // Called at a falling edge; holds the op until in_ready lets it through the next rising edge.
   task automatic applyStimulus(input logic [7:0] op);
      int budget;
      budget   = 0;
      in_op    = op;
      in_valid = 1'b1;
      while (!in_ready && budget < 1000) begin
         @(negedge clock);
         budget++;
      end
      checkOutput("inReady", 32'(in_ready), 32'd1);
      @(negedge clock);
      in_valid = 1'b0;
      modelOp(op);
   endtask

   task automatic waitDrain();
      int budget;
      budget = 0;
      while (expQ.size() != 0 && budget < 500) begin
         @(negedge clock);
         budget++;
      end
      checkOutput("drainDone", 32'(expQ.size()), 32'd0);
      repeat (8) @(negedge clock);
   endtask

   // Beats are compared against the scoreboard head every cycle they are offered, stalled or not.
   always begin
      @(negedge clock);
      #1;
      if (!rst && out_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedBeat", {16'd0, out_data}, 32'hFFFF_FFFF);
         end else begin
            checkOutput("beatData", 32'(out_data), 32'(expQ[0].data));
            checkOutput("beatLast", 32'(out_last), 32'(expQ[0].last));
            if (out_ready) begin
               void'(expQ.pop_front());
               beatSeen++;
            end
         end
      end
      if (!rst && err_op) begin
         errSeen++;
      end
   end

   initial begin
      int idx, lastIdx, nextIdx, errBase, beatBase, pushed;
      checks     = 0;
      passes     = 0;
      errSeen    = 0;
      beatSeen   = 0;
      expErr     = 0;
      modelValue = 16'd0;
      expOpCount = 16'd0;
      rst        = 1'b1;
      in_op      = 8'h00;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      repeat (3) @(negedge clock);
      rst = 1'b0;
      @(negedge clock);

      checkOutput("rstInReady", 32'(in_ready), 32'd1);
      checkOutput("rstOutValid", 32'(out_valid), 32'd0);
      checkOutput("rstOutLast", 32'(out_last), 32'd0);
      checkOutput("rstOutData", 32'(out_data), 32'd0);
      checkOutput("rstErr", 32'(err_op), 32'd0);
      checkOutput("rstOpCount", 32'(op_count), 32'd0);

      // LOAD 5 then two BURSTs: first beat two cycles after its push, one idle cycle between bursts.
      applyStimulus(8'h15);
      applyStimulus(8'h02);
      checkOutput("latencyEarly", 32'(out_valid), 32'd0);
      applyStimulus(8'h02);
      checkOutput("latencyBeat", 32'(out_valid), 32'd1);
      idx     = 0;
      lastIdx = -1;
      nextIdx = -1;
      while (nextIdx < 0 && idx < 60) begin
         if (out_valid && out_ready && out_last && lastIdx < 0) begin
            lastIdx = idx;
         end else if (lastIdx >= 0 && out_valid) begin
            nextIdx = idx;
         end
         @(negedge clock);
         idx++;
      end
      checkOutput("burstGap", 32'(nextIdx - lastIdx), 32'd2);
      waitDrain();
      checkOutput("opCountT2", 32'(op_count), 32'(expOpCount));
      checkOutput("beatsT2", 32'(beatSeen), 32'd8);

      // Consumer backpressure toggling every cycle.
      beatBase = beatSeen;
      applyStimulus(8'h02);
      idx = 0;
      while (expQ.size() != 0 && idx < 100) begin
         out_ready = ~out_ready;
         @(negedge clock);
         idx++;
      end
      out_ready = 1'b1;
      waitDrain();
      checkOutput("beatsT4", 32'(beatSeen - beatBase), 32'd4);

      // Stalled burst fills the FIFO; later ops wait for space and keep their order.
      out_ready = 1'b0;
      applyStimulus(8'h02);
      @(negedge clock);
      checkOutput("burstActive", 32'(out_valid), 32'd1);
      applyStimulus(8'h41);
      applyStimulus(8'h02);
      applyStimulus(8'h00);
      applyStimulus(8'h81);
      checkOutput("fullReady", 32'(in_ready), 32'd0);
      fork
         begin
            applyStimulus(8'h02);
            applyStimulus(8'h02);
         end
         begin
            repeat (3) @(negedge clock);
            out_ready = 1'b1;
         end
      join
      waitDrain();
      checkOutput("opCountT5", 32'(op_count), 32'(expOpCount));

      // Illegal op: single error pulse, no beats, value untouched for the next burst.
      errBase  = errSeen;
      beatBase = beatSeen;
      applyStimulus(8'h03);
      waitDrain();
      checkOutput("errPulse", 32'(errSeen - errBase), 32'd1);
      checkOutput("errNoBeats", 32'(beatSeen - beatBase), 32'd0);
      applyStimulus(8'h02);
      waitDrain();
      checkOutput("errTotal", 32'(errSeen), 32'(expErr));
      checkOutput("opCountT6", 32'(op_count), 32'(expOpCount));

      // Reset in the middle of a stalled burst aborts the stream at once.
      out_ready = 1'b0;
      applyStimulus(8'h02);
      repeat (2) @(negedge clock);
      checkOutput("preRstValid", 32'(out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midRstValid", 32'(out_valid), 32'd0);
      checkOutput("midRstLast", 32'(out_last), 32'd0);
      checkOutput("midRstData", 32'(out_data), 32'd0);
      checkOutput("midRstReady", 32'(in_ready), 32'd1);
      checkOutput("midRstCount", 32'(op_count), 32'd0);
      expQ.delete();
      modelValue = 16'd0;
      expOpCount = 16'd0;
      out_ready  = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      @(negedge clock);

      // 65535 NOPs bring the counter to its top; one more wraps it.
      in_op    = 8'h00;
      in_valid = 1'b1;
      pushed   = 0;
      idx      = 0;
      while (pushed < 65535 && idx < 70000) begin
         if (in_ready) begin
            pushed++;
         end
         @(negedge clock);
         idx++;
      end
      in_valid   = 1'b0;
      expOpCount = expOpCount + 16'(pushed);
      repeat (8) @(negedge clock);
      checkOutput("opCountTop", 32'(op_count), 32'h0000_FFFF);
      applyStimulus(8'h00);
      repeat (4) @(negedge clock);
      checkOutput("opCountWrap", 32'(op_count), 32'(expOpCount));
      checkOutput("opCountZero", 32'(op_count), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
